// File: rtl/ama_riscv_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ama_riscv_fetch_queue
// Purpose  : {pc, inst} decoupling FIFO between imem response and decode;
//            drives a NOP when empty and flushes in one cycle on redirect.
// Revision : 1.0 - initial release
// ============================================================================
module ama_riscv_fetch_queue #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [31:0]            in_pc,
  input  logic [31:0]            in_inst,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_inst,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]  pc_mem_q   [DEPTH];
  logic [31:0]  inst_mem_q [DEPTH];

  logic full, empty, push, pop;
  logic [AW-1:0] wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  assign full  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid  && in_ready  && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = wr_ptr_q - rd_ptr_q;

  assign out_pc   = empty ? 32'h0 : pc_mem_q[rd_idx];
  assign out_inst = empty ? NOP   : inst_mem_q[rd_idx];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; entries are only observable while valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_idx]   <= in_pc;
      inst_mem_q[wr_idx] <= in_inst;
    end
  end

endmodule
`default_nettype wire
